expr_result_misr: RTL and testbench

Result-signature compactor that sits directly downstream of the generated 90-bit expression blocks in the regression bench. It accepts one packed result word per handshake and folds a programmed number of words into a 90-bit multiple-input signature register (MISR). When the run completes, it compares the final signature against an expected value and reports pass/fail. One signature per run replaces per-vector comparison against the reference simulator.

---
 rtl/expr_result_misr.sv | 140 ++++++++++++++
 tb/tb_expr_result_misr.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/expr_result_misr.sv
// expr_result_misr
// Folds a programmed number of result words into a WIDTH-bit multiple-input
// signature register, then compares the final signature against a golden value.
// A single signature per run stands in for comparing every vector.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        one-cycle pulse that begins a run (honoured in IDLE or DONE)
//   num_vectors  number of words in the run, sampled on an accepted start
//   expected     golden signature, sampled on an accepted start
//   in_valid     result word valid
//   in_ready     high while the block accepts words (RUN)
//   in_y         result word
//   busy         high in RUN
//   done         high in DONE
//   pass         final signature matched expected (meaningful while done)
//   signature    current signature register
//   count        words accepted in the current run
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | accepting and folding words until num_vectors are taken
// DONE  | run finished, pass held, waiting for a restart

module expr_result_misr #(
  parameter int unsigned          WIDTH = 90,
  parameter logic [WIDTH-1:0]     POLY  = 90'h2D,
  parameter logic [WIDTH-1:0]     SEED  = '0,
  parameter int unsigned          CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [WIDTH-1:0] expected,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nv_q, nv_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             pass_q, pass_d;

  logic             start_ok;
  logic             accept;
  logic             last_word;
  logic [WIDTH-1:0] sig_fold;

  // Galois-style shift: taps are XORed in when the bit shifted out is set.
  assign sig_fold  = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ in_y;
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign accept    = in_valid && (state_q == S_RUN);
  assign last_word = (cnt_q + CNT_W'(1)) == nv_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      nv_q    <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      nv_q    <= nv_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    nv_d    = nv_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          nv_d  = num_vectors;
          exp_d = expected;
          sig_d = SEED;
          cnt_d = '0;
          if (num_vectors == '0) begin
            // Nothing to fold: the verdict is SEED against the fresh golden value.
            state_d = S_DONE;
            pass_d  = (SEED == expected);
          end else begin
            state_d = S_RUN;
            pass_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          sig_d = sig_fold;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_word) begin
            state_d = S_DONE;
            pass_d  = (sig_fold == exp_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready = (state_q == S_RUN);
    busy     = (state_q == S_RUN);
    done     = (state_q == S_DONE);
  end

  assign pass      = pass_q;
  assign signature = sig_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_expr_result_misr.sv
module tb_expr_result_misr;

  localparam int WIDTH = 90;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic [WIDTH-1:0] expected;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_mis = 0;

  expr_result_misr #(
    .WIDTH(WIDTH),
    .POLY (90'h2D),
    .SEED ('0),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_vectors(num_vectors),
    .expected   (expected),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_y       (in_y),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [CNT_W-1:0] nv, input logic [WIDTH-1:0] ex);
    start       = 1'b1;
    num_vectors = nv;
    expected    = ex;
    tick();
    start = 1'b0;
  endtask

  task automatic word(input logic [WIDTH-1:0] y);
    in_valid = 1'b1;
    in_y     = y;
    tick();
    in_valid = 1'b0;
  endtask

  logic       bub_v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] bub_y [6] = '{8'd5, 8'hAA, 8'hBB, 8'd6, 8'hCC, 8'd7};

  initial begin
    reset = 1'b1; start = 1'b0; num_vectors = '0; expected = '0;
    in_valid = 1'b0; in_y = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sig", signature, 0);
    chk("rst_cnt", count, 0);

    // Single word
    go(1, 1);
    chk("t1_busy", busy, 1);
    chk("t1_ready", in_ready, 1);
    word(1);
    chk("t1_done", done, 1);
    chk("t1_ready_drop", in_ready, 0);
    chk("t1_busy_drop", busy, 0);
    chk("t1_sig", signature, 1);
    chk("t1_cnt", count, 1);
    chk("t1_pass", pass, 1);

    // Shift and XOR, restarted straight from DONE
    go(2, 2);
    chk("t2_busy", busy, 1);
    chk("t2_sig_reload", signature, 0);
    chk("t2_cnt_reload", count, 0);
    word(1);
    chk("t2_cnt_mid", count, 1);
    chk("t2_done_mid", done, 0);
    word(1);
    chk("t2_sig", signature, 3);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);

    // Feedback from the top bit
    go(2, 90'h2D);
    word(90'h1 << 89);
    chk("t3_sig_mid", signature, 90'h1 << 89);
    word(0);
    chk("t3_sig", signature, 90'h2D);
    chk("t3_pass", pass, 1);

    // Bubbles: 5, then (5<<1)^6 = 12, then (12<<1)^7 = 31
    go(3, 31);
    for (int i = 0; i < 6; i++) begin
      in_valid = bub_v[i];
      in_y     = WIDTH'(bub_y[i]);
      tick();
      if (i == 4) begin
        chk("t4_cnt_mid", count, 2);
        chk("t4_busy_mid", busy, 1);
        chk("t4_sig_mid", signature, 12);
      end
    end
    in_valid = 1'b0;
    chk("t4_sig", signature, 31);
    chk("t4_cnt", count, 3);
    chk("t4_done", done, 1);
    chk("t4_pass", pass, 1);
    word(90'hFF);
    word(90'hFF);
    chk("t4_sig_hold", signature, 31);
    chk("t4_cnt_hold", count, 3);
    chk("t4_done_hold", done, 1);

    // Zero length, then restart from DONE
    go(0, 0);
    chk("t5_done0", done, 1);
    chk("t5_pass0", pass, 1);
    chk("t5_busy0", busy, 0);
    go(1, 5);
    chk("t5_busy", busy, 1);
    chk("t5_sig_reload", signature, 0);
    chk("t5_cnt_reload", count, 0);
    go(0, 0);
    chk("t5_start_ignored", busy, 1);
    word(5);
    chk("t5_sig", signature, 5);
    chk("t5_pass", pass, 1);
    go(0, 7);
    chk("t5_zero_fail_done", done, 1);
    chk("t5_zero_fail_pass", pass, 0);
    chk("t5_zero_sig", signature, 0);

    // Reset mid-run
    go(4, 0);
    word(3);
    word(4);
    chk("t6_cnt_mid", count, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_ready", in_ready, 0);
    chk("t6_sig", signature, 0);
    chk("t6_cnt", count, 0);
    chk("t6_pass", pass, 0);
    tick();
    chk("t6_no_done", done, 0);
    go(1, 9);
    word(9);
    chk("t6_sig_run", signature, 9);
    chk("t6_cnt_run", count, 1);
    chk("t6_pass_run", pass, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
